// File: rtl/mul_prod_accum.sv
// Dot-product accumulator that sits behind the sequential multiplier. It counts out
// the multiplier latency after each start, adds the product, and hands the sum downstream.
module mul_prod_accum #(
    parameter int unsigned OP_W        = 8,
    parameter int unsigned ACC_W       = 12,
    parameter int unsigned N_TERMS     = 4,
    parameter int unsigned MUL_LATENCY = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic             clr,
    input  logic             acc_ready,
    output logic             acc_valid,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_ovf,
    output logic [2:0]       term_cnt,
    output logic             busy,
    output logic             lost_start
);

    localparam int unsigned CNT_W = (MUL_LATENCY < 2) ? 1 : $clog2(MUL_LATENCY + 1);
    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [2:0]         term_q, term_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               lost_q, lost_d;

    logic [SUM_W-1:0]   sum_c;
    logic [2:0]         term_inc_c;

    // Extra top bit of the sum is the carry that feeds the sticky overflow flag.
    assign sum_c      = SUM_W'(acc_q) + SUM_W'(op);
    assign term_inc_c = term_q + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            term_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            term_q  <= term_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            lost_q  <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        term_d  = term_q;
        lost_d  = lost_q;

        if (clr) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            acc_d   = '0;
            ovf_d   = 1'b0;
            term_d  = '0;
            lost_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(MUL_LATENCY);
                    end
                end
                S_WAIT: begin
                    // A restart abandons the in-flight product, even on its final edge.
                    if (start) begin
                        cnt_d = CNT_W'(MUL_LATENCY);
                    end else if (cnt_q == CNT_W'(1)) begin
                        cnt_d   = '0;
                        acc_d   = sum_c[ACC_W-1:0];
                        ovf_d   = ovf_q | sum_c[ACC_W];
                        term_d  = term_inc_c;
                        state_d = (term_inc_c == 3'(N_TERMS)) ? S_HOLD : S_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (acc_ready) begin
                        acc_d  = '0;
                        ovf_d  = 1'b0;
                        term_d = '0;
                        if (start) begin
                            state_d = S_WAIT;
                            cnt_d   = CNT_W'(MUL_LATENCY);
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else if (start) begin
                        lost_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Status flags are registered copies of the next state so they track it exactly.
    always_comb begin
        valid_d = (state_d == S_HOLD);
        busy_d  = (state_d == S_WAIT);
    end

    assign acc_valid  = valid_q;
    assign acc_out    = acc_q;
    assign acc_ovf    = ovf_q;
    assign term_cnt   = term_q;
    assign busy       = busy_q;
    assign lost_start = lost_q;

endmodule
